// File: rtl/dsa_debug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsa_debug_pkg
// Description : Shared constants, types and helpers for the bilinear DSA
//               debug trace unit.
//               - W_* constants give the position of each 32-bit word in a
//                 trace entry.
//               - num_words() sizes an entry for a given SIMD width.
//               - trace_entry_t holds one entry at the widest supported SIMD
//                 width. Narrower configurations leave the upper words zero.
// Revision    : 1.0 - initial release
// ============================================================================
package dsa_debug_pkg;

    localparam int W_STATUS = 0;
    localparam int W_COORD  = 1;
    localparam int W_PIXMEM = 2;
    localparam int W_SIMD0  = 3;

    localparam int MAX_SIMD_WIDTH = 8;
    localparam int MAX_NUM_WORDS  = 5;

    // Three fixed words, then one word per group of four SIMD lanes.
    function automatic int num_words(input int simd_width);
        return W_SIMD0 + (simd_width + 3) / 4;
    endfunction

    typedef logic [MAX_NUM_WORDS-1:0][31:0] trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/dsa_debug_trace_if.sv
`default_nettype none
// ============================================================================
// Module      : dsa_debug_trace_if
// Description : Bundles the datapath snapshot, trace control, breakpoint and
//               read-port signals of the debug trace unit.
//               - slave  : the trace unit. It samples the datapath and
//                          control signals, and drives the read data and
//                          status outputs.
//               - master : the datapath, the stepping controller and the
//                          JTAG bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface dsa_debug_trace_if
    import dsa_debug_pkg::*;
#(
    parameter int ADDR_WIDTH  = 18,
    parameter int SIMD_WIDTH  = 4,
    parameter int TRACE_DEPTH = 16
);
    localparam int IDX_W = $clog2(TRACE_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Datapath snapshot
    logic                    mode_simd;
    logic [3:0]              fsm_state_seq;
    logic [3:0]              fsm_state_simd;
    logic [15:0]             current_x;
    logic [15:0]             current_y;
    logic [7:0]              pixel_out_seq;
    logic [8*SIMD_WIDTH-1:0] pixel_out_simd;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_write_en;

    // Trace control
    logic                    capture_enable;
    logic                    step_ack;
    logic                    trace_clear;
    logic                    trace_stop_full;

    // Breakpoint
    logic                    bp_enable;
    logic [15:0]             bp_x;
    logic [15:0]             bp_y;
    logic                    bp_clear;

    // Read port
    logic                    rd_req;
    logic [IDX_W-1:0]        rd_idx;
    logic [2:0]              rd_sel;
    logic                    rd_valid;
    logic [31:0]             rd_data;
    logic                    rd_err;

    // Status
    logic [CNT_W-1:0]        trace_count;
    logic                    trace_overflow;
    logic                    bp_hit;

    modport slave (
        input  mode_simd, fsm_state_seq, fsm_state_simd, current_x, current_y,
               pixel_out_seq, pixel_out_simd, mem_addr, mem_write_en,
               capture_enable, step_ack, trace_clear, trace_stop_full,
               bp_enable, bp_x, bp_y, bp_clear, rd_req, rd_idx, rd_sel,
        output rd_valid, rd_data, rd_err, trace_count, trace_overflow, bp_hit
    );

    modport master (
        output mode_simd, fsm_state_seq, fsm_state_simd, current_x, current_y,
               pixel_out_seq, pixel_out_simd, mem_addr, mem_write_en,
               capture_enable, step_ack, trace_clear, trace_stop_full,
               bp_enable, bp_x, bp_y, bp_clear, rd_req, rd_idx, rd_sel,
        input  rd_valid, rd_data, rd_err, trace_count, trace_overflow, bp_hit
    );

endinterface
`default_nettype wire

// File: rtl/dsa_trace_ram.sv
`default_nettype none
// ============================================================================
// Module      : dsa_trace_ram
// Description : Simple dual-port trace RAM with one write port and one
//               registered read port.
//               A read and a write to the same address in the same cycle
//               return the old contents.
//               Ports:
//               - i_clk   : clock
//               - i_we    : write enable
//               - i_waddr : write address
//               - i_wdata : write data
//               - i_re    : read enable
//               - i_raddr : read address
//               - o_rdata : registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dsa_trace_ram #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  wire logic             i_clk,
    input  wire logic             i_we,
    input  wire logic [AW-1:0]    i_waddr,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_re,
    input  wire logic [AW-1:0]    i_raddr,
    output logic      [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dsa_debug_trace.sv
`default_nettype none
// ============================================================================
// Module      : dsa_debug_trace
// Description : Debug trace unit for the bilinear-interpolation DSA.
//               It captures timestamped datapath snapshots into a circular
//               trace buffer and raises a coordinate breakpoint. A registered
//               read port drains entries oldest-first.
//               Ports:
//               - clk : system clock
//               - rst : synchronous active-high reset
//               - bus : dsa_debug_trace_if.slave. It carries the snapshot
//                       inputs, trace/breakpoint control, the read port and
//                       the status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module dsa_debug_trace
    import dsa_debug_pkg::*;
#(
    parameter int ADDR_WIDTH  = 18,
    parameter int SIMD_WIDTH  = 4,
    parameter int TRACE_DEPTH = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dsa_debug_trace_if.slave bus
);
    localparam int NUM_WORDS  = num_words(SIMD_WIDTH);
    localparam int SIMD_WORDS = NUM_WORDS - W_SIMD0;
    localparam int LANE_W     = SIMD_WORDS * 32;
    localparam int ENTRY_W    = NUM_WORDS * 32;
    localparam int PTR_W      = $clog2(TRACE_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    logic [15:0]             r_timestamp;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [CNT_W-1:0]        r_count;
    logic                    r_overflow;
    logic                    r_bp_hit;
    logic                    r_rd_pend;
    logic                    r_rd_err;
    logic [2:0]              r_rd_sel;

    logic                    w_event;
    logic                    w_full;
    logic                    w_write;
    logic                    w_bp_match;
    logic [3:0]              w_live_state;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [8*SIMD_WIDTH-1:0] w_pix_simd;
    logic [LANE_W-1:0]       w_lanes;
    trace_entry_t            w_entry;
    logic [ENTRY_W-1:0]      w_wdata;
    logic [ENTRY_W-1:0]      w_rdata;
    logic [PTR_W-1:0]        w_oldest;
    logic [PTR_W-1:0]        w_raddr;
    logic                    w_rd_err;
    logic [255:0]            w_row;

    // ------------------------------------------------------------------
    // Capture decision
    // ------------------------------------------------------------------
    assign w_event    = !r_bp_hit &&
                        (bus.capture_enable ? bus.step_ack : bus.mem_write_en);
    assign w_full     = (r_count == CNT_W'(TRACE_DEPTH));
    // trace_clear wins over a same-cycle event, and that event is lost.
    assign w_write    = w_event && !bus.trace_clear &&
                        (!w_full || !bus.trace_stop_full);
    assign w_bp_match = w_event && !bus.trace_clear && bus.bp_enable &&
                        (bus.current_x == bus.bp_x) &&
                        (bus.current_y == bus.bp_y);

    // ------------------------------------------------------------------
    // Entry assembly
    // ------------------------------------------------------------------
    assign w_live_state = bus.mode_simd ? bus.fsm_state_simd : bus.fsm_state_seq;
    assign w_mem_addr   = bus.mem_addr;
    assign w_pix_simd   = bus.pixel_out_simd;
    // Zero-pad the lanes up to whole words so unused lanes read as 0.
    assign w_lanes      = LANE_W'(w_pix_simd);

    always_comb begin
        w_entry           = '0;
        w_entry[W_STATUS] = {r_timestamp, 3'b000, bus.mem_write_en,
                             bus.mode_simd, 3'b000, w_live_state, 4'b0000};
        w_entry[W_COORD]  = {bus.current_y, bus.current_x};
        w_entry[W_PIXMEM] = {bus.pixel_out_seq, 24'(w_mem_addr)};
        for (int k = 0; k < SIMD_WORDS; k++) begin
            w_entry[W_SIMD0 + k] = w_lanes[32*k +: 32];
        end
    end

    assign w_wdata = w_entry[NUM_WORDS-1:0];

    // ------------------------------------------------------------------
    // Buffer state, timestamp and breakpoint
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timestamp <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_bp_hit    <= 1'b0;
        end else begin
            r_timestamp <= r_timestamp + 16'd1;

            if (bus.trace_clear) begin
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_write && !w_full) begin
                    r_count <= r_count + CNT_W'(1);
                end
                if (w_event && w_full) begin
                    r_overflow <= 1'b1;
                end
            end

            // A match in the same cycle as bp_clear wins.
            if (w_bp_match) begin
                r_bp_hit <= 1'b1;
            end else if (bus.bp_clear) begin
                r_bp_hit <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    // r_count wraps to 0 in PTR_W bits when the buffer is full. In that case
    // the oldest entry is the one about to be overwritten at r_wr_ptr.
    assign w_oldest = r_wr_ptr - r_count[PTR_W-1:0];
    assign w_raddr  = w_oldest + bus.rd_idx;
    assign w_rd_err = ({1'b0, bus.rd_idx} >= r_count) ||
                      (bus.rd_sel >= 3'(NUM_WORDS));

    dsa_trace_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (TRACE_DEPTH)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_write),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_re    (bus.rd_req),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
            r_rd_err  <= 1'b0;
            r_rd_sel  <= '0;
        end else begin
            r_rd_pend <= bus.rd_req;
            if (bus.rd_req) begin
                r_rd_err <= w_rd_err;
                r_rd_sel <= bus.rd_sel;
            end
        end
    end

    // Pad the row to eight words so any rd_sel value indexes legally.
    // Out-of-range selects are already forced to zero by r_rd_err.
    assign w_row = 256'(w_rdata);

    assign bus.rd_valid       = r_rd_pend;
    assign bus.rd_err         = r_rd_pend && r_rd_err;
    assign bus.rd_data        = (r_rd_pend && !r_rd_err) ?
                                w_row[{r_rd_sel, 5'b00000} +: 32] : 32'd0;
    assign bus.trace_count    = r_count;
    assign bus.trace_overflow = r_overflow;
    assign bus.bp_hit         = r_bp_hit;

endmodule
`default_nettype wire

// File: doc/dsa_debug_trace.md
# dsa_debug_trace

Parametrised debug trace unit for the bilinear-interpolation DSA. It records timestamped snapshots of datapath state into a circular trace buffer on each stepping acknowledge, or on each memory write when free-running. It raises a coordinate breakpoint that halts the stepping controller. A registered read port lets the JTAG bridge drain entries oldest-first, generalising the fixed single-snapshot debug registers to any SIMD width and trace depth.

## Interface
- ADDR_WIDTH, 18, memory address width (≤ 24)
- SIMD_WIDTH, 4, SIMD lanes (1..8)
- TRACE_DEPTH, 16, entries in buffer (power of 2, ≥ 2)
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- mode_simd  in  1  1 = SIMD datapath active
- fsm_state_seq, fsm_state_simd  in  4 each  FSM states
- current_x, current_y  in  16 each  current output coordinate
- pixel_out_seq  in  8  sequential output pixel
- pixel_out_simd  in  8*SIMD_WIDTH  lane i at bits [8i+7:8i]
- mem_addr  in  ADDR_WIDTH  memory address
- mem_write_en  in  1  memory write strobe
- capture_enable  in  1  1 = stepping mode
- step_ack  in  1  single-cycle step acknowledge
- trace_clear  in  1  pulse: empty buffer, clear overflow
- trace_stop_full  in  1  1 = stop capturing when full; 0 = overwrite oldest
- bp_enable  in  1  breakpoint armed
- bp_x, bp_y  in  16 each  breakpoint coordinate
- bp_clear  in  1  pulse: clear bp_hit
- rd_req  in  1  read request pulse
- rd_idx  in  $clog2(TRACE_DEPTH)  entry offset from oldest
- rd_sel  in  3  word within entry
- rd_valid  out  1  read data valid
- rd_data  out  32  read word
- rd_err  out  1  with rd_valid: rd_idx ≥ count or rd_sel ≥ NUM_WORDS
- trace_count  out  $clog2(TRACE_DEPTH)+1  valid entries
- trace_overflow  out  1  sticky: an entry was overwritten or dropped
- bp_hit  out  1  sticky breakpoint flag; also the halt request

## Operation
- Capture event: (capture_enable & step_ack) | (!capture_enable & mem_write_en). Events are gated off while bp_hit = 1.
- Entry layout, with NUM_WORDS = 3 + ceil(SIMD_WIDTH/4):
  - w0 = {timestamp[15:0], 3'b0, mem_write_en, mode_simd, 3'b0, live_state[3:0], 4'b0}, where live_state = mode_simd ? fsm_state_simd : fsm_state_seq.
  - w1 = {current_y, current_x}.
  - w2 = {pixel_out_seq, zero-extended mem_addr[23:0]}.
  - w3.. = SIMD pixels, 4 lanes per word, lane 0 in LSB; unused lanes are 0.
- Timestamp: 16-bit free-running cycle counter. Cleared by rst; wraps 0xFFFF→0.
- Buffer state: wr_ptr, count. Oldest entry = wr_ptr − count (mod DEPTH).
- Event, not full: write at wr_ptr, wr_ptr++, count++.
- Event, full, trace_stop_full = 0: write at wr_ptr, wr_ptr++, count unchanged, trace_overflow ← 1.
- Event, full, trace_stop_full = 1: entry dropped, trace_overflow ← 1.
- Breakpoint: on an event with bp_enable and (current_x, current_y) == (bp_x, bp_y):
  - that entry is still written;
  - bp_hit ← 1 on the following edge.
- bp_clear clears bp_hit; if a matching event occurs in the same cycle, set wins.
- trace_clear: wr_ptr ← 0, count ← 0, overflow ← 0. It beats a same-cycle event, and the event is lost.
- Read:
  - rd_req samples rd_idx/rd_sel and the current oldest pointer.
  - Data is for entry (oldest + rd_idx) as of that cycle. A same-cycle capture is not visible.
  - Error case: rd_data = 0, rd_err = 1.

## Timing
- Reset values: rd_valid 0, rd_data 0, rd_err 0, trace_count 0, trace_overflow 0, bp_hit 0, timestamp 0. Buffer RAM contents are don't-care.
- Capture at edge N: trace_count updates at N+1. A rd_req in cycle N+1 sees the entry.
- Read latency: rd_req at edge N → rd_valid/rd_data/rd_err high for exactly cycle N+1. Back-to-back requests are accepted every cycle.
- Capture and read may occur in the same cycle (dual-port); neither stalls.
- rst mid-read suppresses the pending rd_valid.

## Structure
- Package dsa_debug_pkg holds:
  - word index constants W_STATUS = 0, W_COORD = 1, W_PIXMEM = 2, W_SIMD0 = 3;
  - function num_words(simd_width);
  - typedef trace_entry_t (packed, NUM_WORDS×32).
- Sub-module dsa_trace_ram: simple dual-port, one write port, one registered read port, width NUM_WORDS×32, depth TRACE_DEPTH.
- The word mux selected by rd_sel follows the RAM read register.

## Test plan
- Step capture: capture_enable = 1, 3 step_acks at (x,y) = (1,0),(2,0),(3,0) → trace_count = 3; rd_idx = 2, rd_sel = 1 returns 0x0000_0003 one cycle after rd_req.
- Wrap: DEPTH = 16, trace_stop_full = 0, 20 events with x = 0..19 → count = 16, overflow = 1, rd_idx = 0 w1 returns x = 4.
- Stop-full: same stimulus with trace_stop_full = 1 → rd_idx = 15 returns x = 15, overflow = 1.
- Breakpoint: bp = (5,2), events at x = 4,5,6 on y = 2 → bp_hit = 1 after x = 5; count stops at 2; bp_clear reopens capture.
- Free-run/SIMD: capture_enable = 0, SIMD_WIDTH = 8, mem_write_en with lanes 0x10..0x17 → w3 = 0x1312_1110, w4 = 0x1716_1514; rd_sel = 5 gives rd_err = 1.
- Clear collision: trace_clear and an event in the same cycle → count = 0; rd_idx = 0 returns rd_err = 1.
